// File: rtl/usb4_lane_pkg.sv
`default_nettype none
// ============================================================================
// Module   : usb4_lane_pkg
// Purpose  : Lane-level receive FSM state encodings and default widths shared
//            by the serializer, deserializer and transaction FSMs.
// Revision : 1.0 - initial release
// ============================================================================
package usb4_lane_pkg;

  // Receive FSM state encodings; 2'h3 is reserved and treated as disconnected
  localparam logic [1:0] DISCONNECTED_S = 2'h0;
  localparam logic [1:0] IDLE_S         = 2'h1;
  localparam logic [1:0] START          = 2'h2;

  // Default parallel word width on the lane
  localparam int DEFAULT_DATA_WIDTH = 8;

endpackage
`default_nettype wire

// File: rtl/rx_word_fifo.sv
`default_nettype none
// ============================================================================
// Module   : rx_word_fifo
// Purpose  : Two-entry word FIFO between word assembly and the consumer.
//            A push into a full FIFO is accepted only if a pop happens in
//            the same cycle; otherwise the pushed word is ignored.
// Revision : 1.0 - initial release
// ============================================================================
module rx_word_fifo
  import usb4_lane_pkg::*;
#(
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  push,
  input  logic [DATA_WIDTH-1:0] push_data,
  input  logic                  pop,
  output logic                  full,
  output logic                  empty,
  output logic [DATA_WIDTH-1:0] head
);

  logic [DATA_WIDTH-1:0] mem [2];
  logic                  wr_ptr;
  logic                  rd_ptr;
  logic [1:0]            count;
  logic                  do_push;
  logic                  do_pop;

  assign full    = (count == 2'd2);
  assign empty   = (count == 2'd0);
  assign head    = mem[rd_ptr];
  assign do_pop  = pop && !empty;
  // When full, the popped slot is the one being written, so a simultaneous
  // push is safe: the old head is consumed on this same edge.
  assign do_push = push && (!full || do_pop);

  // Storage, pointers and occupancy; everything cleared on reset
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mem[0] <= '0;
      mem[1] <= '0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= ~wr_ptr;
      end
      if (do_pop) begin
        rd_ptr <= ~rd_ptr;
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: rtl/deserializer.sv
`default_nettype none
// ============================================================================
// Module   : deserializer
// Purpose  : Samples the serial lane LSB-first during START, assembles words
//            into a 2-entry output buffer with valid/ready, flags dropped
//            words, and reports idle/disconnected line state.
// Revision : 1.0 - initial release
// ============================================================================
module deserializer
  import usb4_lane_pkg::*;
#(
  parameter int DATA_WIDTH  = DEFAULT_DATA_WIDTH,
  parameter int IDLE_DETECT = 16,
  parameter int DISC_DETECT = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [1:0]            rx_state,
  input  logic                  serial_in,
  output logic [DATA_WIDTH-1:0] parallel_out,
  output logic                  data_valid,
  input  logic                  data_ready,
  output logic                  overflow,
  input  logic                  overflow_clr,
  output logic                  line_idle,
  output logic                  line_disconnected
);

  localparam int CNT_W  = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam int ONES_W = $clog2(IDLE_DETECT + 1);
  localparam int ZERO_W = $clog2(DISC_DETECT + 1);

  logic [DATA_WIDTH-1:0] shift;
  logic [CNT_W-1:0]      bit_cnt;
  logic [ONES_W-1:0]     ones_cnt;
  logic [ZERO_W-1:0]     zeros_cnt;
  logic                  in_start;
  logic                  last_bit;
  logic [DATA_WIDTH-1:0] word;
  logic                  push;
  logic                  pop;
  logic                  full;
  logic                  empty;

  assign in_start   = (rx_state == START);
  assign last_bit   = (bit_cnt == CNT_W'(DATA_WIDTH - 1));
  assign word       = {serial_in, shift[DATA_WIDTH-1:1]};
  assign push       = in_start && last_bit;
  assign data_valid = !empty;
  assign pop        = data_valid && data_ready;

  rx_word_fifo #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_data (word),
    .pop       (pop),
    .full      (full),
    .empty     (empty),
    .head      (parallel_out)
  );

  // Word assembly: shift in during START, abandon partial word otherwise
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      shift   <= '0;
      bit_cnt <= '0;
    end else if (in_start) begin
      shift   <= word;
      bit_cnt <= last_bit ? '0 : bit_cnt + CNT_W'(1);
    end else begin
      bit_cnt <= '0;
    end
  end

  // Sticky overflow: a drop on the same edge as a clear keeps the flag set
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      overflow <= 1'b0;
    end else if (push && full && !pop) begin
      overflow <= 1'b1;
    end else if (overflow_clr) begin
      overflow <= 1'b0;
    end
  end

  // Saturating run-length counters of consecutive ones and zeros
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ones_cnt  <= '0;
      zeros_cnt <= '0;
    end else if (serial_in) begin
      zeros_cnt <= '0;
      if (ones_cnt != ONES_W'(IDLE_DETECT)) ones_cnt <= ones_cnt + ONES_W'(1);
    end else begin
      ones_cnt <= '0;
      if (zeros_cnt != ZERO_W'(DISC_DETECT)) zeros_cnt <= zeros_cnt + ZERO_W'(1);
    end
  end

  // Registered line-state flags; at most one run counter is nonzero at a time
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      line_idle         <= 1'b0;
      line_disconnected <= 1'b0;
    end else begin
      line_idle         <= (ones_cnt >= ONES_W'(IDLE_DETECT));
      line_disconnected <= (zeros_cnt >= ZERO_W'(DISC_DETECT));
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_deserializer.sv
`default_nettype none
// ============================================================================
// Module   : tb_deserializer
// Purpose  : Directed self-checking bench for the deserializer.
// Revision : 1.0 - initial release
// ============================================================================
module tb_deserializer;
  import usb4_lane_pkg::*;

  logic       clk;
  logic       rst;
  logic [1:0] rx_state;
  logic       serial_in;
  logic [7:0] parallel_out;
  logic       data_valid;
  logic       data_ready;
  logic       overflow;
  logic       overflow_clr;
  logic       line_idle;
  logic       line_disconnected;

  int n_vec = 0;
  int n_err = 0;

  deserializer #(
    .DATA_WIDTH  (8),
    .IDLE_DETECT (16),
    .DISC_DETECT (16)
  ) dut (
    .clk               (clk),
    .rst               (rst),
    .rx_state          (rx_state),
    .serial_in         (serial_in),
    .parallel_out      (parallel_out),
    .data_valid        (data_valid),
    .data_ready        (data_ready),
    .overflow          (overflow),
    .overflow_clr      (overflow_clr),
    .line_idle         (line_idle),
    .line_disconnected (line_disconnected)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Timeout guard
  initial begin
    #100000;
    $display("FAIL timeout: bench did not finish, got running required done");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", tag, obs, exp);
    end
  endtask

  // Advance one edge; inputs change and outputs are sampled 1 time unit after it
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_word(input logic [7:0] w);
    rx_state = START;
    for (int i = 0; i < 8; i++) begin
      serial_in = w[i];
      tick();
    end
  endtask

  initial begin
    rst          = 1'b0;
    rx_state     = IDLE_S;
    serial_in    = 1'b0;
    data_ready   = 1'b0;
    overflow_clr = 1'b0;
    tick();
    tick();
    check("rst_valid", 32'(data_valid), 32'd0);
    check("rst_out",   32'(parallel_out), 32'h00);
    check("rst_ovf",   32'(overflow), 32'd0);
    check("rst_idle",  32'(line_idle), 32'd0);
    check("rst_disc",  32'(line_disconnected), 32'd0);
    rst = 1'b1;
    tick();

    // Basic: two back-to-back words with consumer always ready
    data_ready = 1'b1;
    send_word(8'hA5);
    check("basic_v1",   32'(data_valid), 32'd1);
    check("basic_w1",   32'(parallel_out), 32'hA5);
    for (int i = 0; i < 8; i++) begin
      serial_in = 1'(8'h3C >> i);
      tick();
      if (i == 0) check("basic_gap", 32'(data_valid), 32'd0);
    end
    check("basic_v2",   32'(data_valid), 32'd1);
    check("basic_w2",   32'(parallel_out), 32'h3C);
    check("basic_ovf",  32'(overflow), 32'd0);
    rx_state = IDLE_S;
    tick();
    check("basic_drain", 32'(data_valid), 32'd0);

    // Backpressure: third word dropped, overflow set
    data_ready = 1'b0;
    send_word(8'h11);
    check("bp_v1",  32'(data_valid), 32'd1);
    check("bp_w1",  32'(parallel_out), 32'h11);
    send_word(8'h22);
    check("bp_ovf0", 32'(overflow), 32'd0);
    send_word(8'h33);
    check("bp_ovf1", 32'(overflow), 32'd1);
    check("bp_hold", 32'(parallel_out), 32'h11);
    rx_state   = IDLE_S;
    data_ready = 1'b1;
    tick();
    check("bp_pop1", 32'(parallel_out), 32'h22);
    check("bp_pop1v", 32'(data_valid), 32'd1);
    tick();
    check("bp_empty", 32'(data_valid), 32'd0);
    check("bp_ovf_sticky", 32'(overflow), 32'd1);
    overflow_clr = 1'b1;
    tick();
    overflow_clr = 1'b0;
    check("bp_ovf_clr", 32'(overflow), 32'd0);

    // Abort mid-word: three bits of START, then IDLE, then a clean word
    rx_state = START;
    for (int i = 0; i < 3; i++) begin
      serial_in = 1'b1;
      tick();
    end
    rx_state = IDLE_S;
    tick();
    tick();
    check("abort_none", 32'(data_valid), 32'd0);
    send_word(8'h5A);
    check("abort_v",   32'(data_valid), 32'd1);
    check("abort_w",   32'(parallel_out), 32'h5A);
    rx_state = IDLE_S;
    tick();
    check("abort_single", 32'(data_valid), 32'd0);

    // Line state detection
    serial_in = 1'b1;
    for (int i = 0; i < 16; i++) tick();
    check("idle_pre", 32'(line_idle), 32'd0);
    tick();
    check("idle_set", 32'(line_idle), 32'd1);
    check("idle_nodisc", 32'(line_disconnected), 32'd0);
    serial_in = 1'b0;
    tick();
    check("idle_hold", 32'(line_idle), 32'd1);
    serial_in = 1'b1;
    tick();
    check("idle_clr", 32'(line_idle), 32'd0);
    serial_in = 1'b0;
    for (int i = 0; i < 16; i++) tick();
    check("disc_pre", 32'(line_disconnected), 32'd0);
    tick();
    check("disc_set", 32'(line_disconnected), 32'd1);
    check("disc_noidle", 32'(line_idle), 32'd0);

    // Full buffer with simultaneous pop and push
    data_ready = 1'b0;
    send_word(8'h44);
    send_word(8'h55);
    for (int i = 0; i < 8; i++) begin
      serial_in = 1'(8'h66 >> i);
      if (i == 7) data_ready = 1'b1;
      tick();
    end
    check("simul_ovf", 32'(overflow), 32'd0);
    check("simul_w1",  32'(parallel_out), 32'h55);
    rx_state = IDLE_S;
    tick();
    check("simul_w2",  32'(parallel_out), 32'h66);
    tick();
    check("simul_empty", 32'(data_valid), 32'd0);

    // Clear coinciding with a drop: set wins
    data_ready = 1'b0;
    send_word(8'h77);
    send_word(8'h88);
    for (int i = 0; i < 8; i++) begin
      serial_in = 1'(8'h99 >> i);
      if (i == 7) overflow_clr = 1'b1;
      tick();
    end
    overflow_clr = 1'b0;
    check("setwins_ovf", 32'(overflow), 32'd1);
    check("setwins_head", 32'(parallel_out), 32'h77);

    // Reset mid-word with one word buffered
    rx_state   = IDLE_S;
    data_ready = 1'b1;
    tick();
    data_ready = 1'b0;
    check("prerst_w", 32'(parallel_out), 32'h88);
    rx_state = START;
    for (int i = 0; i < 4; i++) begin
      serial_in = 1'(i % 2 == 0);
      tick();
    end
    #2;
    rst = 1'b0;
    #1;
    check("mrst_valid", 32'(data_valid), 32'd0);
    check("mrst_out",   32'(parallel_out), 32'h00);
    check("mrst_ovf",   32'(overflow), 32'd0);
    check("mrst_idle",  32'(line_idle), 32'd0);
    check("mrst_disc",  32'(line_disconnected), 32'd0);
    rx_state = IDLE_S;
    tick();
    rst = 1'b1;
    rx_state = START;
    for (int i = 0; i < 8; i++) begin
      serial_in = 1'(8'hC3 >> i);
      tick();
      if (i == 6) check("post_nospur", 32'(data_valid), 32'd0);
    end
    check("post_v", 32'(data_valid), 32'd1);
    check("post_w", 32'(parallel_out), 32'hC3);
    rx_state   = IDLE_S;
    data_ready = 1'b1;
    tick();
    check("post_single", 32'(data_valid), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/deserializer.md
Name: deserializer

Overview:
Receive-side counterpart of the lane serializer. It samples the serial line LSB-first while the receive FSM reports START and assembles DATA_WIDTH-bit words. Completed words go into a 2-entry output buffer with a valid/ready handshake. It also reports line state (idle = sustained ones, disconnected = sustained zeros) to the receive FSM, and sits between the lane input and the receive-side transaction logic.

Parameters:
DATA_WIDTH, 8, width of each parallel word; bits arrive LSB first.
IDLE_DETECT, 16, number of consecutive 1 samples that asserts line_idle (>=2).
DISC_DETECT, 16, number of consecutive 0 samples that asserts line_disconnected (>=2).

Ports:
clk  input  1  clock; all logic on posedge.
rst  input  1  reset, asynchronous, active-low.
rx_state  input  2  receive FSM state: 0 DISCONNECTED_S, 1 IDLE_S, 2 START, 3 reserved (treated as DISCONNECTED_S).
serial_in  input  1  serial line, synchronous to clk.
parallel_out  output  DATA_WIDTH  head word of the output buffer.
data_valid  output  1  parallel_out holds a valid word.
data_ready  input  1  consumer accepts the head word when data_valid && data_ready.
overflow  output  1  sticky flag: a completed word was dropped because the buffer was full.
overflow_clr  input  1  synchronous clear of overflow.
line_idle  output  1  at least IDLE_DETECT consecutive 1s have been sampled.
line_disconnected  output  1  at least DISC_DETECT consecutive 0s have been sampled.

Behaviour:
- Reset (rst=0, async): shift register, bit counter, buffer and run counters go to 0. parallel_out=0, data_valid=0, overflow=0, line_idle=0, line_disconnected=0.
- Alignment: the integration delays rx_state so that the first cycle with rx_state==START samples bit 0 of the first word. Each following START cycle samples the next bit; words follow back-to-back with no gap.
- Assembly, in every START cycle:
  - shift <= {serial_in, shift[DATA_WIDTH-1:1]}; bit counter increments.
  - When the counter equals DATA_WIDTH-1, the word {serial_in, shift[DATA_WIDTH-1:1]} is pushed into the buffer and the counter wraps to 0.
- Leaving START (any other rx_state): the partial word is discarded and the counter returns to 0. The next START restarts at bit 0. The shift register holds its value (don't-care).
- Latency: a pushed word appears at parallel_out with data_valid=1 on the cycle after its last bit is sampled, provided the buffer was empty.
- Output buffer: 2-entry FIFO.
  - Pop occurs when data_valid && data_ready.
  - Push and pop in the same cycle are both performed, whatever the occupancy.
  - Push into a full buffer with no pop in that cycle: the new word is dropped, stored words are unchanged, and overflow is set on the next edge.
  - parallel_out is stable while data_valid=1 and data_ready=0.
  - Buffer contents survive rx_state changes and are cleared only by reset.
- overflow: sticky. overflow_clr=1 clears it. If a set and a clear happen in the same cycle, the set wins.
- Line detectors run in every rx_state:
  - ones_cnt and zeros_cnt saturate at IDLE_DETECT and DISC_DETECT respectively; a sample of the opposite value resets the counter to 0.
  - line_idle = (ones_cnt >= IDLE_DETECT), registered; same rule for line_disconnected with zeros_cnt.
  - The first opposite-value sample deasserts the flag on the next edge.
  - The two flags are never both 1.
- Reset mid-word: the partial word and buffer contents are lost. No data_valid is produced after reset until a full new word is assembled.

Decomposition:
- Package usb4_lane_pkg holds:
  - localparams DISCONNECTED_S=2'h0, IDLE_S=2'h1, START=2'h2, shared with the serializer and the transaction FSMs;
  - default DATA_WIDTH.
- Sub-module rx_word_fifo (parameter DATA_WIDTH, depth fixed at 2) implements push, pop, full, empty and head output. The deserializer owns assembly, overflow and the line detectors.

Test Plan:
- Basic: rx_state=START for 16 cycles, serial LSB-first 0xA5 then 0x3C, data_ready=1 -> data_valid pulses one cycle after bit 7 with 0xA5, then 8 cycles later with 0x3C; overflow=0.
- Backpressure: data_ready=0, three words 0x11, 0x22, 0x33 -> buffer holds 0x11 then 0x22, 0x33 dropped, overflow=1. Raise data_ready -> 0x11 then 0x22 in consecutive cycles. Then overflow_clr=1 -> overflow=0.
- Abort mid-word: START for 3 bits, IDLE_S for 2 cycles, then START with 0x5A -> only 0x5A delivered, no spurious word.
- Line state: serial_in=1 for 16 cycles -> line_idle=1 on the edge after the 16th sample; a single 0 -> line_idle=0. serial_in=0 for 16 cycles -> line_disconnected=1.
- Simultaneous events: buffer full, pop and push in the same cycle -> no overflow, order preserved. overflow_clr together with a drop -> overflow stays 1.
- Reset mid-word: assert rst after bit 4 with one word buffered -> all outputs 0 at once. After release, a full 0xC3 -> a single valid word 0xC3.
